// File: rtl/uart_rx_fifo_if.sv
// Valid/ready stream carrying received UART words and their per-word status flags.
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] m_data;
    logic              m_perr;
    logic              m_ferr;
    logic              m_break;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output m_data,
        output m_perr,
        output m_ferr,
        output m_break,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_perr,
        input  m_ferr,
        input  m_break,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime word length, parity and stop-bit count, 3-sample majority voting,
// and a first-word-fall-through FIFO whose head entry and flags are registered.
module uart_rx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 13
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx,
    input  logic [CNT_W-1:0]             clks_per_bit,
    input  logic [3:0]                   data_bits,
    input  logic [1:0]                   parity_mode,
    input  logic                         two_stop,
    uart_rx_fifo_if.master               m,
    output logic                         overrun,
    input  logic                         clr_overrun,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = DATA_W + 3;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2,
        StResync
    } state_e;

    // Synchronizer and edge history
    logic sync1_q, rs_q, rs_prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= 1'b1;
            rs_q      <= 1'b1;
            rs_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx;
            rs_q      <= sync1_q;
            rs_prev_q <= rs_q;
        end
    end

    // Receiver state
    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q, cpb_q;
    logic [3:0]        bits_q, bit_idx_q;
    logic              par_en_q, par_odd_q, two_stop_q;
    logic              s0_q, s1_q;
    logic [DATA_W-1:0] data_q;
    logic              par_bit_q, perr_q, busy_q;

    logic [CNT_W-1:0]  half;
    logic              at_s0, at_s1, at_dec, at_end, maj;
    logic [3:0]        bits_eff;
    logic              stop_dec, push, push_ferr, push_brk;
    logic [EW-1:0]     push_word;

    assign half   = cpb_q >> 1;
    assign at_s0  = (cnt_q == half - CNT_W'(1));
    assign at_s1  = (cnt_q == half);
    assign at_dec = (cnt_q == half + CNT_W'(1));
    assign at_end = (cnt_q == cpb_q - CNT_W'(1));
    assign maj    = (s0_q & s1_q) | (s0_q & rs_q) | (s1_q & rs_q);

    assign bits_eff = (data_bits < 4'd5 || data_bits > 4'(DATA_W)) ? 4'(DATA_W) : data_bits;

    assign stop_dec  = (state_q == StStop1 || state_q == StStop2) && at_dec;
    assign push      = stop_dec && (!maj || state_q == StStop2 || !two_stop_q);
    assign push_ferr = !maj;
    assign push_brk  = !maj && (data_q == '0) && !par_bit_q;
    assign push_word = {push_brk, push_ferr, perr_q, data_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cpb_q      <= '0;
            bits_q     <= '0;
            bit_idx_q  <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            data_q     <= '0;
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (at_s0) s0_q <= rs_q;
            if (at_s1) s1_q <= rs_q;
            cnt_q <= at_end ? '0 : cnt_q + CNT_W'(1);

            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (rs_prev_q && !rs_q) begin
                        // Frame format is frozen for the whole frame from here on
                        state_q    <= StStart;
                        busy_q     <= 1'b1;
                        cpb_q      <= clks_per_bit;
                        bits_q     <= bits_eff;
                        par_en_q   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                        par_odd_q  <= (parity_mode == 2'b10);
                        two_stop_q <= two_stop;
                        bit_idx_q  <= '0;
                        data_q     <= '0;
                        par_bit_q  <= 1'b0;
                        perr_q     <= 1'b0;
                    end
                end
                StStart: begin
                    if (at_dec && maj) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (at_end) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (at_dec) begin
                        for (int i = 0; i < int'(DATA_W); i++) begin
                            if (bit_idx_q == 4'(i)) data_q[i] <= maj;
                        end
                    end
                    if (at_end) begin
                        if (bit_idx_q == bits_q - 4'd1) begin
                            state_q <= par_en_q ? StParity : StStop1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end
                end
                StParity: begin
                    if (at_dec) begin
                        par_bit_q <= maj;
                        perr_q    <= ((^data_q) ^ maj) != par_odd_q;
                    end
                    if (at_end) state_q <= StStop1;
                end
                StStop1: begin
                    if (at_dec && !maj) begin
                        state_q <= StResync;
                    end else if (at_dec && !two_stop_q) begin
                        // Leave at mid-stop so an early next start edge is not missed
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (at_end) begin
                        state_q <= StStop2;
                    end
                end
                StStop2: begin
                    if (at_dec) begin
                        if (!maj) begin
                            state_q <= StResync;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                StResync: begin
                    cnt_q <= '0;
                    if (rs_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output FIFO
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d, level_after_pop;
    logic [EW-1:0] head_q, head_d;
    logic          overrun_q;
    logic          full, pop, wr_en;

    assign full            = (level_q == LW'(FIFO_DEPTH));
    assign pop             = (level_q != '0) && m.m_ready;
    assign wr_en           = push && (!full || pop);
    assign rd_ptr_d        = rd_ptr_q + AW'(pop);
    assign level_after_pop = level_q - LW'(pop);
    assign level_d         = level_after_pop + LW'(wr_en);

    always_comb begin
        head_d = head_q;
        if (level_d == '0) begin
            head_d = '0;
        end else if (level_after_pop == '0) begin
            // FIFO drains to only the incoming word, so it bypasses storage
            head_d = push_word;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            head_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            if (push && full && !pop) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign m.m_data  = head_q[DATA_W-1:0];
    assign m.m_perr  = head_q[DATA_W];
    assign m.m_ferr  = head_q[DATA_W+1];
    assign m.m_break = head_q[DATA_W+2];
    assign m.m_valid = (level_q != '0);
    assign overrun   = overrun_q;
    assign busy      = busy_q;
    assign level     = level_q;

endmodule
